uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit byte channel (tx_wen/uart_din/tx_full on mmio_bus) among NREQ requesters.
//  Round-robin, message-granular: a grant is held until the requester sends EOM_BYTE, or until it stalls
//  for LOCK_TIMEOUT cycles, so console lines from different sources never interleave.
//  Sits between the requesters (CPU MMIO store path, debug monitor, ...) and uart_controller.
// PARAMETERS
//  NREQ          2       number of requesters, >=2
//  EOM_BYTE      8'h0A   end-of-message byte; accepting it releases the grant
//  LOCK_TIMEOUT  1024    cycles with no accepted byte, while granted, before the grant is revoked; >=2
// PORTS
//  clk        in   1          system clock
//  Rst        in   1          asynchronous reset, active-low
//  req_valid  in   NREQ       requester i has a byte on req_data[8*i+:8]
//  req_data   in   8*NREQ     packed request bytes
//  req_ready  out  NREQ       byte of requester i accepted this cycle (valid&ready)
//  tx_full    in   1          downstream TX FIFO full
//  tx_wen     out  1          one-cycle write strobe to uart_controller
//  uart_din   out  8          byte written with tx_wen
//  grant_id   out  $clog2(NREQ)  current/last granted requester
//  busy       out  1          a requester holds the grant
// BEHAVIOUR
//  - Reset (Rst=0, async): state IDLE, rr_ptr=0, tx_wen=0, uart_din=0, grant_id=0, busy=0, req_ready=0, timer=0.
//  - FSM IDLE -> [TAG] -> SEND -> IDLE. States registered; req_ready combinational from registered state.
//  - IDLE: if any req_valid, grant first valid index searching from rr_ptr upward, wrapping; grant_id,busy=1
//    registered next cycle; state -> SEND (or TAG). No valid: stay IDLE. Decision costs 1 cycle.
//  - Accept rule: req_ready[g] = (state==SEND) & (g==grant_id) & ~tx_full & ~tx_wen. Max 1 byte / 2 cycles.
//  - Accepted byte -> uart_din registered, tx_wen=1 exactly one cycle later; tx_wen never held 2 cycles.
//  - tx_full sampled same cycle as accept; tx_full while tx_wen pending is downstream's concern (1-entry slack).
//  - Accepting EOM_BYTE: byte still written; state -> IDLE; rr_ptr = grant_id+1 mod NREQ; busy=0 next cycle.
//  - Timeout: timer clears on each accept and on grant, increments each SEND cycle without accept;
//    at timer==LOCK_TIMEOUT-1 -> IDLE, rr_ptr advances as for EOM, no byte emitted. tx_full stall also counts.
//  - Requester may drop req_valid mid-message; grant held until EOM or timeout. Non-granted req_valid ignored.
//  - Reset mid-message: pending tx_wen discarded, all state to reset values; no partial strobe.
//  - grant_id retains last value in IDLE; only busy indicates ownership.
// CONFIGURATION
//  UART_ARB_TAG_EN defined: after grant, state TAG emits one byte ("0"+grant_id, i.e. 8'h30+g) via tx_wen
//    before SEND, subject to ~tx_full & ~tx_wen; TAG cycles count toward timeout? No: timer frozen in TAG.
//  UART_ARB_TAG_EN undefined: TAG state absent; IDLE -> SEND directly; output stream is raw bytes only.
// STRUCTURE
//  Shared package uart_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_TAG, ARB_SEND} uart_arb_state_t;
//    constants ASCII_LF=8'h0A, ASCII_ZERO=8'h30.
//  Sub-module uart_rr_picker (combinational): inputs req vector + rr_ptr, outputs found + index.
//  Timer width $clog2(LOCK_TIMEOUT); saturation not needed (release at terminal count).
// TESTING
//  1. Single req0 sends "AB\n", tx_full=0 -> tx_wen pulses carry 41,42,0A in order, 1 cycle after each ready; busy 0 after.
//  2. req0 and req1 both valid from same cycle, each "X\n"/"Y\n" -> req0 first (rr_ptr=0), then req1; no interleave.
//  3. req1 holds grant, sends "Q" then drops valid -> grant revoked exactly LOCK_TIMEOUT cycles after last accept; req0 then served.
//  4. tx_full=1 for 50 cycles mid-message -> req_ready=0, no tx_wen; resumes on first cycle tx_full=0.
//  5. Rst low while tx_wen pending -> tx_wen=0, uart_din=0, busy=0 immediately (async); no byte emitted.
//  6. UART_ARB_TAG_EN, req1 sends "Z\n" -> tx_wen bytes 31,5A,0A; without macro -> 5A,0A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: arbiter FSM state encoding and the ASCII
// codes used for message framing and requester tags.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_TAG  = 2'd1,
    ARB_SEND = 2'd2
  } uart_arb_state_t;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping around to index 0.
module uart_rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of the UART TX byte channel.
// Optional UART_ARB_TAG_EN: emit an ASCII requester tag ("0"+id) at the start of each grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NREQ         = 2,
  parameter logic [7:0] EOM_BYTE     = ASCII_LF,
  parameter int         LOCK_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    tx_full,
  output logic                    tx_wen,
  output logic [7:0]              uart_din,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(LOCK_TIMEOUT);

  uart_arb_state_t state_reg, state_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic            busy_reg, busy_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            wen_reg, wen_next;
  logic [7:0]      din_reg, din_next;

  logic            found;
  logic [IW-1:0]   pick_idx;
  logic            can_write;
  logic            accept;
  logic [7:0]      grant_byte;
  logic [IW-1:0]   ptr_after;

  uart_rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .found  (found),
    .index  (pick_idx)
  );

  // A byte may only be taken when nothing is waiting to be strobed out.
  assign can_write  = ~tx_full & ~wen_reg;
  assign grant_byte = req_data[{grant_reg, 3'b000} +: 8];
  assign accept     = (state_reg == ARB_SEND) & can_write & req_valid[grant_reg];
  assign ptr_after  = (grant_reg == IW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == ARB_SEND) && (grant_reg == IW'(gi)) && can_write;
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    busy_next   = busy_reg;
    timer_next  = timer_reg;
    wen_next    = 1'b0;
    din_next    = din_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (found) begin
          grant_next = pick_idx;
          busy_next  = 1'b1;
          timer_next = '0;
`ifdef UART_ARB_TAG_EN
          state_next = ARB_TAG;
`else
          state_next = ARB_SEND;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      // Timer stays frozen while the tag byte waits for room downstream.
      ARB_TAG: begin
        if (can_write) begin
          wen_next   = 1'b1;
          din_next   = ASCII_ZERO + 8'(grant_reg);
          state_next = ARB_SEND;
        end
      end
`endif
      ARB_SEND: begin
        if (accept) begin
          wen_next   = 1'b1;
          din_next   = grant_byte;
          timer_next = '0;
          if (grant_byte == EOM_BYTE) begin
            state_next  = ARB_IDLE;
            busy_next   = 1'b0;
            rr_ptr_next = ptr_after;
          end
        end else if (timer_reg == TW'(LOCK_TIMEOUT - 1)) begin
          state_next  = ARB_IDLE;
          busy_next   = 1'b0;
          rr_ptr_next = ptr_after;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_reg  <= ARB_IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      busy_reg   <= 1'b0;
      timer_reg  <= '0;
      wen_reg    <= 1'b0;
      din_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      busy_reg   <= busy_next;
      timer_reg  <= timer_next;
      wen_reg    <= wen_next;
      din_reg    <= din_next;
    end
  end

  assign tx_wen   = wen_reg;
  assign uart_din = din_reg;
  assign grant_id = grant_reg;
  assign busy     = busy_reg;

endmodule
